// File: rtl/dfh_chain_walker.sv
// ---------------------------------------------------------------------------
// dfh_chain_walker
//
// Walks a Device Feature Header (DFH) linked list in MMIO space. A start pulse
// launches 64-bit reads beginning at base_addr. Each returned DFH is emitted
// as one record on a valid/ready stream. The walker then follows the
// next-DFH byte offset until it reaches an end-of-list (EOL) header or hits
// an error.
//
// DFH layout: [63:60] type, [40] EOL, [39:16] next offset, [11:0] feature ID.
//
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   start           one-cycle pulse; honoured only while idle
//   base_addr       first DFH byte address (8-byte aligned)
//   busy            a walk is in progress
//   done            one-cycle pulse at the end of a walk
//   error/err_code  sticky result of the last walk; cleared on start
//                   (1 = zero offset without EOL, 2 = MAX_FEATURES exceeded,
//                    3 = response timeout)
//   feature_count   records emitted in the last/current walk
//   rd_req_*        MMIO read request channel (valid/ready, byte address)
//   rd_rsp_*        MMIO read response; accepted only while waiting for one
//   feat_*          discovered feature record stream (valid/ready)
//
// Optional build macro DFH_WALK_RSP_TIMEOUT_EN:
//   When defined, a wait counter aborts the walk with err_code 3 if no read
//   response arrives within RSP_TIMEOUT cycles. When undefined, the walker
//   waits for a response indefinitely.
// ---------------------------------------------------------------------------
module dfh_chain_walker #(
  parameter int ADDR_W       = 32,
  parameter int MAX_FEATURES = 64,
  parameter int RSP_TIMEOUT  = 4096
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [ADDR_W-1:0]                 base_addr,
  output logic                              busy,
  output logic                              done,
  output logic                              error,
  output logic [1:0]                        err_code,
  output logic [$clog2(MAX_FEATURES+1)-1:0] feature_count,
  output logic                              rd_req_valid,
  input  logic                              rd_req_ready,
  output logic [ADDR_W-1:0]                 rd_req_addr,
  input  logic                              rd_rsp_valid,
  input  logic [63:0]                       rd_rsp_data,
  output logic                              feat_valid,
  input  logic                              feat_ready,
  output logic [ADDR_W-1:0]                 feat_addr,
  output logic [63:0]                       feat_dfh,
  output logic [$clog2(MAX_FEATURES)-1:0]   feat_idx
);

  localparam int CNT_W = $clog2(MAX_FEATURES + 1);
  localparam int IDX_W = $clog2(MAX_FEATURES);

  localparam logic [1:0] ERR_ZERO_OFFSET = 2'd1;
  localparam logic [1:0] ERR_TOO_MANY    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT     = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    EMIT,
    CHECK,
    DONE,
    ERR
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] cur_addr;

  // Fields of the DFH captured into feat_dfh. The header stays in feat_dfh
  // after the record handshake, so CHECK decodes it from there.
  logic              dfh_eol;
  logic [23:0]       dfh_next;
  logic [ADDR_W-1:0] next_addr;

  assign dfh_eol   = feat_dfh[40];
  assign dfh_next  = feat_dfh[39:16];
  // The offset is unsigned and zero-extended; the sum wraps at ADDR_W bits.
  assign next_addr = cur_addr + ADDR_W'(dfh_next);

`ifdef DFH_WALK_RSP_TIMEOUT_EN
  localparam int TMO_W = $clog2(RSP_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RSP_TIMEOUT - 1);

  logic [TMO_W-1:0] wait_cnt;
`else
  // The timeout length only matters when the timeout counter is built.
  logic unused_rsp_timeout;
  assign unused_rsp_timeout = (RSP_TIMEOUT > 0);
`endif

  // Walker FSM. All outputs are registered here. done defaults low every
  // cycle, so any cycle that raises it produces a single-cycle pulse. busy
  // drops on the same edge that raises done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cur_addr      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      err_code      <= 2'd0;
      feature_count <= '0;
      rd_req_valid  <= 1'b0;
      rd_req_addr   <= '0;
      feat_valid    <= 1'b0;
      feat_addr     <= '0;
      feat_dfh      <= '0;
      feat_idx      <= '0;
`ifdef DFH_WALK_RSP_TIMEOUT_EN
      wait_cnt      <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cur_addr      <= base_addr;
            rd_req_addr   <= base_addr;
            rd_req_valid  <= 1'b1;
            error         <= 1'b0;
            err_code      <= 2'd0;
            feature_count <= '0;
            busy          <= 1'b1;
            state         <= REQ;
          end
        end

        REQ: begin
          // The request address stays put until it is accepted.
          if (rd_req_ready) begin
            rd_req_valid <= 1'b0;
`ifdef DFH_WALK_RSP_TIMEOUT_EN
            wait_cnt     <= '0;
`endif
            state        <= WAIT;
          end
        end

        WAIT: begin
          if (rd_rsp_valid) begin
            feat_dfh   <= rd_rsp_data;
            feat_addr  <= cur_addr;
            feat_idx   <= feature_count[IDX_W-1:0];
            feat_valid <= 1'b1;
            state      <= EMIT;
          end
`ifdef DFH_WALK_RSP_TIMEOUT_EN
          else if (wait_cnt == TMO_LAST) begin
            // No record is emitted for a header that never arrived.
            error    <= 1'b1;
            err_code <= ERR_TIMEOUT;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= ERR;
          end else begin
            wait_cnt <= wait_cnt + TMO_W'(1);
          end
`endif
        end

        EMIT: begin
          if (feat_ready) begin
            feat_valid    <= 1'b0;
            feature_count <= feature_count + CNT_W'(1);
            state         <= CHECK;
          end
        end

        CHECK: begin
          // feature_count already includes the record that was just emitted.
          if (dfh_eol) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else if (dfh_next == 24'd0) begin
            error    <= 1'b1;
            err_code <= ERR_ZERO_OFFSET;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= ERR;
          end else if (feature_count == CNT_W'(MAX_FEATURES)) begin
            error    <= 1'b1;
            err_code <= ERR_TOO_MANY;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= ERR;
          end else begin
            cur_addr     <= next_addr;
            rd_req_addr  <= next_addr;
            rd_req_valid <= 1'b1;
            state        <= REQ;
          end
        end

        // Terminal states last one cycle while done pulses. A start pulse
        // seen here is ignored.
        DONE: state <= IDLE;
        ERR:  state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule
